// File: rtl/ptw_pkg.sv
// Shared definitions for the page-table walker: FSM state type, PTE flag bit
// positions, PTE/line geometry, the Sysbus read tag and an address-merge helper.
package ptw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } ptw_state_e;

  // PTE flag bit positions
  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;

  localparam int unsigned PTE_SIZE   = 8;
  localparam int unsigned LINE_BYTES = 64;

  // Sysbus read-from-memory tag: SYSBUS_READ<<12 | SYSBUS_MEMORY<<8
  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam logic [12:0] SYSBUS_READ_MEM_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

  // Keep the low off_bits of va, take everything above from base.
  function automatic logic [63:0] merge_offset(input logic [63:0] base,
                                               input logic [63:0] va,
                                               input int unsigned off_bits);
    logic [63:0] mask;
    mask = (64'd1 << off_bits) - 64'd1;
    return (base & ~mask) | (va & mask);
  endfunction

endpackage

// File: rtl/ptw_pte_check.sv
// Combinational classification of one captured page-table entry.
//   pte       : captured PTE (flags [9:0], PPN above)
//   level     : level the PTE was read at
//   vaddr     : virtual address being translated
//   fault     : invalid, reserved W-without-R, misaligned superpage, or
//               pointer at the last level
//   leaf      : R or X set
//   paddr     : assembled physical address for a valid leaf, else 0
//   next_base : PPN << page offset (next table base, or leaf page base)
module ptw_pte_check
  import ptw_pkg::*;
#(
  parameter int unsigned VPN_WIDTH         = 9,
  parameter int unsigned PAGE_OFFSET_WIDTH = 12,
  parameter int unsigned PPN_WIDTH         = 44
) (
  input  logic [63:0] pte,
  input  logic [1:0]  level,
  input  logic [63:0] vaddr,
  output logic        fault,
  output logic        leaf,
  output logic [63:0] paddr,
  output logic [63:0] next_base
);

  logic                 v, r, w, x;
  logic [PPN_WIDTH-1:0] ppn;
  logic [PPN_WIDTH-1:0] align_mask;
  logic [63:0]          base;

  logic unused_pte_bits;
  assign unused_pte_bits = ^{pte[63:10+PPN_WIDTH], pte[9:4]};

  always_comb begin
    v          = pte[PTE_V];
    r          = pte[PTE_R];
    w          = pte[PTE_W];
    x          = pte[PTE_X];
    ppn        = pte[10 +: PPN_WIDTH];
    base       = 64'(ppn) << PAGE_OFFSET_WIDTH;
    // PPN bits that a superpage at this level must leave clear
    align_mask = (PPN_WIDTH'(1) << (32'(level) * VPN_WIDTH)) - PPN_WIDTH'(1);
    leaf       = r | x;
    fault      = 1'b0;
    paddr      = '0;
    if (!v || (!r && w)) begin
      fault = 1'b1;
    end else if (leaf) begin
      if (level != 2'd0 && (ppn & align_mask) != '0) begin
        fault = 1'b1;
      end else begin
        paddr = merge_offset(base, vaddr, PAGE_OFFSET_WIDTH + 32'(level) * VPN_WIDTH);
      end
    end else if (level == 2'd0) begin
      fault = 1'b1;
    end
  end

  assign next_base = base;

endmodule

// File: rtl/page_table_walker.sv
// Radix page-table walker (Sv39/Sv48 style) with a single-entry
// last-translation register.
//   clk, reset            : clock, synchronous active-high reset
//   satp_ppn              : root table PPN
//   flush                 : invalidate the last-translation register
//   req_valid/req_ready   : translation request handshake, req_vaddr address
//   resp_valid            : one-cycle result strobe with resp_paddr,
//                           resp_fault, resp_level
//   bus_reqcyc/bus_reqack : line read request, bus_req address, bus_reqtag tag
//   bus_respcyc/respack   : response beats on bus_resp (bus_resptag ignored)
module page_table_walker
  import ptw_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH    = 64,
  parameter int unsigned BUS_TAG_WIDTH     = 13,
  parameter int unsigned LEVELS            = 3,
  parameter int unsigned VPN_WIDTH         = 9,
  parameter int unsigned PAGE_OFFSET_WIDTH = 12,
  parameter int unsigned PPN_WIDTH         = 44,
  parameter int unsigned BEATS_PER_LINE    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PPN_WIDTH-1:0]      satp_ppn,
  input  logic                      flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [63:0]               req_vaddr,
  output logic                      resp_valid,
  output logic [63:0]               resp_paddr,
  output logic                      resp_fault,
  output logic [1:0]                resp_level,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int unsigned VA_WIDTH  = PAGE_OFFSET_WIDTH + LEVELS * VPN_WIDTH;
  localparam int unsigned VPN_ALL   = LEVELS * VPN_WIDTH;
  localparam int unsigned BEAT_W    = $clog2(BEATS_PER_LINE);
  localparam int unsigned PTE_SHIFT = $clog2(PTE_SIZE);
  localparam logic [1:0]  TOP_LEVEL = 2'(LEVELS - 1);

  ptw_state_e         state;
  logic [1:0]         lvl;
  logic [63:0]        vaddr_q;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [BEAT_W-1:0]  beat_sel;
  logic [63:0]        pte_q;

  logic               ltr_valid;
  logic [VPN_ALL-1:0] ltr_vpn;
  logic [63:0]        ltr_base;
  logic [1:0]         ltr_level;

  logic               accept, hit, canonical;
  logic [VPN_ALL-1:0] req_vpn;
  logic [63:0]        hit_paddr, first_pte_addr, next_pte_addr;
  logic               chk_fault, chk_leaf;
  logic [63:0]        chk_paddr, chk_next_base;

  logic unused_resptag;
  assign unused_resptag = ^bus_resptag;

  // Address of the PTE for level l: table base + vpn[l] * PTE_SIZE
  function automatic logic [63:0] pte_index_addr(input logic [63:0] a,
                                                 input logic [63:0] va,
                                                 input logic [1:0]  l);
    logic [63:0] vpn;
    vpn = (va >> (PAGE_OFFSET_WIDTH + 32'(l) * VPN_WIDTH)) & ((64'd1 << VPN_WIDTH) - 64'd1);
    return a + (vpn << PTE_SHIFT);
  endfunction

  function automatic logic [BUS_DATA_WIDTH-1:0] line_addr(input logic [63:0] a);
    return BUS_DATA_WIDTH'(a & ~64'(LINE_BYTES - 1));
  endfunction

  assign accept    = req_valid && req_ready;
  assign req_vpn   = req_vaddr[PAGE_OFFSET_WIDTH +: VPN_ALL];
  // A flush in the accept cycle forces a miss
  assign hit       = ltr_valid && !flush && (ltr_vpn == req_vpn);
  assign canonical = (&req_vaddr[63:VA_WIDTH-1]) || !(|req_vaddr[63:VA_WIDTH-1]);
  assign hit_paddr = merge_offset(ltr_base, req_vaddr,
                                  PAGE_OFFSET_WIDTH + 32'(ltr_level) * VPN_WIDTH);
  assign first_pte_addr = pte_index_addr(64'(satp_ppn) << PAGE_OFFSET_WIDTH,
                                         req_vaddr, TOP_LEVEL);
  assign next_pte_addr  = pte_index_addr(chk_next_base, vaddr_q, lvl - 2'd1);

  // Beats are acked while walking and also in IDLE, so a line abandoned by
  // reset drains without stalling the bus.
  assign bus_respack = bus_respcyc && (state == ST_WAIT || state == ST_IDLE);

  ptw_pte_check #(
    .VPN_WIDTH        (VPN_WIDTH),
    .PAGE_OFFSET_WIDTH(PAGE_OFFSET_WIDTH),
    .PPN_WIDTH        (PPN_WIDTH)
  ) u_pte_check (
    .pte      (pte_q),
    .level    (lvl),
    .vaddr    (vaddr_q),
    .fault    (chk_fault),
    .leaf     (chk_leaf),
    .paddr    (chk_paddr),
    .next_base(chk_next_base)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_paddr <= '0;
      resp_fault <= 1'b0;
      resp_level <= '0;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
      bus_reqtag <= '0;
      lvl        <= '0;
      vaddr_q    <= '0;
      beat_cnt   <= '0;
      beat_sel   <= '0;
      pte_q      <= '0;
      ltr_valid  <= 1'b0;
      ltr_vpn    <= '0;
      ltr_base   <= '0;
      ltr_level  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            vaddr_q   <= req_vaddr;
            if (hit) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b0;
              resp_paddr <= hit_paddr;
              resp_level <= ltr_level;
              state      <= ST_DONE;
            end else if (!canonical) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_paddr <= '0;
              resp_level <= '0;
              state      <= ST_DONE;
            end else begin
              lvl        <= TOP_LEVEL;
              beat_sel   <= first_pte_addr[PTE_SHIFT +: BEAT_W];
              bus_reqcyc <= 1'b1;
              bus_req    <= line_addr(first_pte_addr);
              bus_reqtag <= BUS_TAG_WIDTH'(SYSBUS_READ_MEM_TAG);
              state      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus_reqack) begin
            bus_reqcyc <= 1'b0;
            bus_req    <= '0;
            bus_reqtag <= '0;
            beat_cnt   <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus_respcyc) begin
            if (beat_cnt == beat_sel) pte_q <= 64'(bus_resp);
            if (beat_cnt == BEAT_W'(BEATS_PER_LINE - 1)) state <= ST_CHECK;
            else beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (chk_fault) begin
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
            resp_paddr <= '0;
            resp_level <= lvl;
            state      <= ST_DONE;
          end else if (chk_leaf) begin
            resp_valid <= 1'b1;
            resp_fault <= 1'b0;
            resp_paddr <= chk_paddr;
            resp_level <= lvl;
            ltr_valid  <= 1'b1;
            ltr_vpn    <= vaddr_q[PAGE_OFFSET_WIDTH +: VPN_ALL];
            ltr_base   <= chk_next_base;
            ltr_level  <= lvl;
            state      <= ST_DONE;
          end else begin
            lvl        <= lvl - 2'd1;
            beat_sel   <= next_pte_addr[PTE_SHIFT +: BEAT_W];
            bus_reqcyc <= 1'b1;
            bus_req    <= line_addr(next_pte_addr);
            bus_reqtag <= BUS_TAG_WIDTH'(SYSBUS_READ_MEM_TAG);
            state      <= ST_REQ;
          end
        end
        ST_DONE: begin
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_paddr <= '0;
          resp_level <= '0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      // flush wins over a same-cycle load of the register
      if (flush) ltr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_page_table_walker.sv
// Directed bench for page_table_walker (LEVELS=3, satp_ppn=0x80000).
module tb_page_table_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic [43:0] satp_ppn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_vaddr;
  logic        resp_valid;
  logic [63:0] resp_paddr;
  logic        resp_fault;
  logic [1:0]  resp_level;
  logic        bus_reqcyc;
  logic        bus_reqack;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_respcyc;
  logic        bus_respack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  page_table_walker #(
    .BUS_DATA_WIDTH   (64),
    .BUS_TAG_WIDTH    (13),
    .LEVELS           (3),
    .VPN_WIDTH        (9),
    .PAGE_OFFSET_WIDTH(12),
    .PPN_WIDTH        (44),
    .BEATS_PER_LINE   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .satp_ppn   (satp_ppn),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_vaddr  (req_vaddr),
    .resp_valid (resp_valid),
    .resp_paddr (resp_paddr),
    .resp_fault (resp_fault),
    .resp_level (resp_level),
    .bus_reqcyc (bus_reqcyc),
    .bus_reqack (bus_reqack),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_respcyc(bus_respcyc),
    .bus_respack(bus_respack),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns at T+1 (#1 after the accept edge).
  task automatic issue(input logic [63:0] va, input logic with_flush);
    req_vaddr = va;
    req_valid = 1'b1;
    flush     = with_flush;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
  endtask

  // Bus memory model: wait (bounded) for a read, hold it one cycle unacked,
  // ack, then stream n_beats beats with pte on beat index `beat`.
  task automatic bus_read(input int beat, input logic [63:0] pte, input int n_beats,
                          output logic [63:0] addr, output logic [12:0] tag,
                          output logic stable, output logic acks_ok, output logic timeout);
    int waited = 0;
    timeout = 1'b0;
    stable  = 1'b1;
    acks_ok = 1'b1;
    addr    = '0;
    tag     = '0;
    while (bus_reqcyc !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    if (bus_reqcyc !== 1'b1) begin
      timeout = 1'b1;
      return;
    end
    addr = bus_req;
    tag  = bus_reqtag;
    tick();
    if (bus_reqcyc !== 1'b1 || bus_req !== addr || bus_reqtag !== tag) stable = 1'b0;
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    for (int b = 0; b < n_beats; b++) begin
      bus_respcyc = 1'b1;
      bus_resp    = (b == beat) ? pte : 64'h0;
      #1;
      if (bus_respack !== 1'b1) acks_ok = 1'b0;
      tick();
    end
    bus_respcyc = 1'b0;
    bus_resp    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0h want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0h want 0", resp_valid); end
    checks++; if (bus_reqcyc !== 1'b0) begin errors++; $display("FAIL reset_reqcyc got %0h want 0", bus_reqcyc); end
    checks++; if (bus_reqtag !== 13'h0 || bus_req !== 64'h0) begin errors++; $display("FAIL reset_bus got req=%0h tag=%0h want 0/0", bus_req, bus_reqtag); end
    reset = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0h want 1", req_ready); end
  endtask

  task automatic test_walk3();
    logic [63:0] a; logic [12:0] t; logic st, ak, to;
    issue(64'h401234, 1'b0);
    checks++; if (bus_reqcyc !== 1'b1) begin errors++; $display("FAIL walk3_reqcyc_t1 got %0h want 1", bus_reqcyc); end
    bus_read(0, 64'h20000401, 8, a, t, st, ak, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL walk3_l2_timeout got %0h want 0", to); end
    checks++; if (a !== 64'h80000000) begin errors++; $display("FAIL walk3_l2_addr got %0h want 80000000", a); end
    checks++; if (t !== 13'h1100) begin errors++; $display("FAIL walk3_tag got %0h want 1100", t); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL walk3_req_stable got %0h want 1", st); end
    checks++; if (ak !== 1'b1) begin errors++; $display("FAIL walk3_respack got %0h want 1", ak); end
    tick();
    bus_read(2, 64'h20000801, 8, a, t, st, ak, to);
    checks++; if (a !== 64'h80001000) begin errors++; $display("FAIL walk3_l1_addr got %0h want 80001000", a); end
    tick();
    bus_read(1, 64'h20000C0F, 8, a, t, st, ak, to);
    checks++; if (a !== 64'h80002000) begin errors++; $display("FAIL walk3_l0_addr got %0h want 80002000", a); end
    tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL walk3_valid got %0h want 1", resp_valid); end
    checks++; if (resp_paddr !== 64'h80003234) begin errors++; $display("FAIL walk3_paddr got %0h want 80003234", resp_paddr); end
    checks++; if (resp_level !== 2'd0 || resp_fault !== 1'b0) begin errors++; $display("FAIL walk3_level_fault got %0h/%0h want 0/0", resp_level, resp_fault); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL walk3_valid_pulse got %0h want 0", resp_valid); end
  endtask

  task automatic test_hit();
    issue(64'h401FF0, 1'b0);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL hit_valid_t1 got %0h want 1", resp_valid); end
    checks++; if (resp_paddr !== 64'h80003FF0) begin errors++; $display("FAIL hit_paddr got %0h want 80003ff0", resp_paddr); end
    checks++; if (bus_reqcyc !== 1'b0) begin errors++; $display("FAIL hit_reqcyc got %0h want 0", bus_reqcyc); end
    tick();
    checks++; if (resp_valid !== 1'b0 || bus_reqcyc !== 1'b0) begin errors++; $display("FAIL hit_after got valid=%0h reqcyc=%0h want 0/0", resp_valid, bus_reqcyc); end
  endtask

  task automatic test_flush_superpage();
    logic [63:0] a; logic [12:0] t; logic st, ak, to;
    issue(64'h401234, 1'b1);
    checks++; if (bus_reqcyc !== 1'b1) begin errors++; $display("FAIL flush_miss_reqcyc got %0h want 1", bus_reqcyc); end
    bus_read(0, 64'h20000401, 8, a, t, st, ak, to);
    tick();
    bus_read(2, 64'h2008000F, 8, a, t, st, ak, to);
    checks++; if (a !== 64'h80001000) begin errors++; $display("FAIL super_l1_addr got %0h want 80001000", a); end
    tick();
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL super_valid got %0h want 1", resp_valid); end
    checks++; if (resp_paddr !== 64'h80201234) begin errors++; $display("FAIL super_paddr got %0h want 80201234", resp_paddr); end
    checks++; if (resp_level !== 2'd1 || resp_fault !== 1'b0) begin errors++; $display("FAIL super_level_fault got %0h/%0h want 1/0", resp_level, resp_fault); end
    tick();
    issue(64'h401FF0, 1'b0);
    checks++; if (resp_valid !== 1'b1 || bus_reqcyc !== 1'b0) begin errors++; $display("FAIL super_hit got valid=%0h reqcyc=%0h want 1/0", resp_valid, bus_reqcyc); end
    checks++; if (resp_paddr !== 64'h80201FF0 || resp_level !== 2'd1) begin errors++; $display("FAIL super_hit_paddr got %0h lvl %0h want 80201ff0 lvl 1", resp_paddr, resp_level); end
    tick();
  endtask

  task automatic test_misaligned();
    logic [63:0] a; logic [12:0] t; logic st, ak, to;
    int extra = 0;
    issue(64'h401234, 1'b1);
    checks++; if (bus_reqcyc !== 1'b1) begin errors++; $display("FAIL misal_reqcyc got %0h want 1", bus_reqcyc); end
    bus_read(0, 64'h20000401, 8, a, t, st, ak, to);
    tick();
    bus_read(2, 64'h2000080F, 8, a, t, st, ak, to);
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1) begin errors++; $display("FAIL misal_fault got valid=%0h fault=%0h want 1/1", resp_valid, resp_fault); end
    checks++; if (resp_paddr !== 64'h0) begin errors++; $display("FAIL misal_paddr got %0h want 0", resp_paddr); end
    for (int c = 0; c < 5; c++) begin
      if (bus_reqcyc === 1'b1) extra++;
      tick();
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL misal_no_read got %0d req cycles want 0", extra); end
  endtask

  task automatic test_invalid_pte();
    logic [63:0] a; logic [12:0] t; logic st, ak, to;
    int extra = 0;
    // the faulting walk above must not have loaded the register: this misses
    issue(64'h401234, 1'b0);
    checks++; if (bus_reqcyc !== 1'b1) begin errors++; $display("FAIL fault_no_ltr got reqcyc=%0h want 1", bus_reqcyc); end
    bus_read(0, 64'h20000400, 8, a, t, st, ak, to);
    checks++; if (a !== 64'h80000000) begin errors++; $display("FAIL inval_addr got %0h want 80000000", a); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_paddr !== 64'h0) begin errors++; $display("FAIL inval_fault got valid=%0h fault=%0h paddr=%0h want 1/1/0", resp_valid, resp_fault, resp_paddr); end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus_reqcyc === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL inval_no_read got %0d req cycles want 0", extra); end
  endtask

  task automatic test_noncanonical();
    issue(64'h0000_8000_0000_0000, 1'b0);
    checks++; if (resp_valid !== 1'b1 || resp_fault !== 1'b1) begin errors++; $display("FAIL noncanon_fault got valid=%0h fault=%0h want 1/1", resp_valid, resp_fault); end
    checks++; if (resp_paddr !== 64'h0 || bus_reqcyc !== 1'b0) begin errors++; $display("FAIL noncanon_bus got paddr=%0h reqcyc=%0h want 0/0", resp_paddr, bus_reqcyc); end
    tick();
    checks++; if (bus_reqcyc !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL noncanon_after got reqcyc=%0h valid=%0h want 0/0", bus_reqcyc, resp_valid); end
  endtask

  task automatic test_reset_midwalk();
    logic [63:0] a; logic [12:0] t; logic st, ak, to;
    int bad_ack = 0;
    int spurious = 0;
    issue(64'h401234, 1'b0);
    bus_read(0, 64'h20000401, 3, a, t, st, ak, to);
    bus_respcyc = 1'b1;
    bus_resp    = 64'h0;
    reset       = 1'b1;
    tick();
    reset       = 1'b0;
    checks++; if (resp_valid !== 1'b0 || bus_reqcyc !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got valid=%0h reqcyc=%0h ready=%0h want 0/0/0", resp_valid, bus_reqcyc, req_ready); end
    checks++; if (bus_req !== 64'h0 || resp_paddr !== 64'h0 || resp_fault !== 1'b0) begin errors++; $display("FAIL midreset_data got req=%0h paddr=%0h fault=%0h want 0/0/0", bus_req, resp_paddr, resp_fault); end
    for (int b = 4; b < 8; b++) begin
      bus_respcyc = 1'b1;
      #1;
      if (bus_respack !== 1'b1) bad_ack++;
      tick();
      if (resp_valid === 1'b1 || bus_reqcyc === 1'b1) spurious++;
    end
    bus_respcyc = 1'b0;
    checks++; if (bad_ack !== 0) begin errors++; $display("FAIL stray_ack got %0d unacked beats want 0", bad_ack); end
    checks++; if (spurious !== 0) begin errors++; $display("FAIL stray_activity got %0d cycles want 0", spurious); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %0h want 1", req_ready); end
    issue(64'h401234, 1'b0);
    checks++; if (bus_reqcyc !== 1'b1) begin errors++; $display("FAIL rewalk_reqcyc got %0h want 1", bus_reqcyc); end
    bus_read(0, 64'h20000401, 8, a, t, st, ak, to);
    checks++; if (a !== 64'h80000000) begin errors++; $display("FAIL rewalk_l2_addr got %0h want 80000000", a); end
    tick();
    bus_read(2, 64'h20000801, 8, a, t, st, ak, to);
    tick();
    bus_read(1, 64'h20000C0F, 8, a, t, st, ak, to);
    checks++; if (a !== 64'h80002000) begin errors++; $display("FAIL rewalk_l0_addr got %0h want 80002000", a); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_paddr !== 64'h80003234 || resp_fault !== 1'b0) begin errors++; $display("FAIL rewalk_result got valid=%0h paddr=%0h fault=%0h want 1/80003234/0", resp_valid, resp_paddr, resp_fault); end
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    satp_ppn    = 44'h80000;
    flush       = 1'b0;
    req_valid   = 1'b0;
    req_vaddr   = '0;
    bus_reqack  = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp    = '0;
    bus_resptag = '0;
    test_reset();
    test_walk3();
    test_hit();
    test_flush_superpage();
    test_misaligned();
    test_invalid_pte();
    test_noncanonical();
    test_reset_midwalk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
